// File: rtl/spi_frame_loader.sv
// Byte-stream command decoder that loads column words into the display framebuffer.
// Supports full-frame and row-window loads, multi-byte channels and a brightness register.
module spi_frame_loader #(
  parameter int          SEGMENTS     = 1,
  parameter int          ROWS         = 8,
  parameter int          COLUMNS      = 32,
  parameter int          CHANNELS     = 3,
  parameter int          BITWIDTH     = 8,
  parameter logic [7:0]  BRIGHT_RESET = 8'hFF,
  localparam int         W            = SEGMENTS * CHANNELS * BITWIDTH,
  localparam int         RW           = $clog2(ROWS),
  localparam int         CW           = $clog2(COLUMNS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_sot,
  input  logic          in_eot,
  input  logic          ready,
  output logic [W-1:0]  wdata,
  output logic          wen,
  output logic [RW-1:0] wrow,
  output logic [CW-1:0] wcol,
  output logic          loaded,
  output logic          error,
  output logic [7:0]    brightness,
  output logic          busy
);

  localparam int BPC = (BITWIDTH + 7) / 8;
  localparam int CHW = 8 * BPC;
  localparam int NCH = SEGMENTS * CHANNELS;
  localparam int BCW = $clog2(BPC + 1);
  localparam int CCW = $clog2(NCH + 1);

  typedef enum logic [2:0] {
    IDLE, ARGS, DATA, DONE, BRIGHT, DROP
  } state_t;

  state_t         state, state_n;
  logic [RW-1:0]  row, row_n;
  logic [RW-1:0]  last, last_n;
  logic [CW-1:0]  col, col_n;
  logic [BCW-1:0] bcnt, bcnt_n;
  logic [CCW-1:0] ccnt, ccnt_n;
  logic [CHW-1:0] ch_acc, ch_acc_n;
  logic [CHW-1:0] acc_next;
  logic [W-1:0]   col_acc, col_acc_n;
  logic [W-1:0]   col_next;
  logic [BITWIDTH-1:0] chan_val;
  logic [7:0]     start, start_n;
  logic           argc, argc_n;
  logic [8:0]     span;
  logic           win_ok;
  logic           chan_done;
  logic           col_done;

  logic [W-1:0]   wdata_n;
  logic [RW-1:0]  wrow_n;
  logic [CW-1:0]  wcol_n;
  logic           wen_n;
  logic           loaded_n;
  logic           error_n;
  logic [7:0]     bright_n;

  // Big-endian channel bytes shift in; the first channel ends up at the top.
  assign acc_next  = (ch_acc << 8) | CHW'(in_data);
  assign chan_val  = acc_next[BITWIDTH-1:0];
  assign col_next  = (col_acc << BITWIDTH) | W'(chan_val);
  assign chan_done = bcnt == BCW'(BPC - 1);
  assign col_done  = chan_done && (ccnt == CCW'(NCH - 1));

  assign span   = {1'b0, start} + {1'b0, in_data};
  assign win_ok = ({1'b0, start} < 9'(ROWS)) &&
                  (in_data != 8'd0) &&
                  (span <= 9'(ROWS));

  assign busy = state != IDLE;

  always_comb begin
    state_n   = state;
    row_n     = row;
    last_n    = last;
    col_n     = col;
    bcnt_n    = bcnt;
    ccnt_n    = ccnt;
    ch_acc_n  = ch_acc;
    col_acc_n = col_acc;
    start_n   = start;
    argc_n    = argc;
    wdata_n   = wdata;
    wrow_n    = wrow;
    wcol_n    = wcol;
    wen_n     = 1'b0;
    loaded_n  = 1'b0;
    error_n   = 1'b0;
    bright_n  = brightness;

    if (in_valid && in_sot) begin
      // A start byte outside IDLE means the previous EOT went missing.
      if (state != IDLE) error_n = 1'b1;
      row_n  = '0;
      col_n  = '0;
      bcnt_n = '0;
      ccnt_n = '0;
      argc_n = 1'b0;
      last_n = RW'(ROWS - 1);
      unique case (1'b1)
        (in_data == 8'hF0 && ready): state_n = DATA;
        (in_data == 8'hF1 && ready): state_n = ARGS;
        (in_data == 8'hF2):          state_n = BRIGHT;
        default: begin
          error_n = 1'b1;
          state_n = DROP;
        end
      endcase
    end else if (in_valid) begin
      unique case (state)
        ARGS: begin
          if (!argc) begin
            start_n = in_data;
            argc_n  = 1'b1;
          end else if (win_ok) begin
            state_n = DATA;
            row_n   = RW'(start);
            last_n  = RW'(span - 9'd1);
          end else begin
            error_n = 1'b1;
            state_n = DROP;
          end
        end
        DATA: begin
          ch_acc_n = acc_next;
          bcnt_n   = bcnt + 1'b1;
          if (chan_done) begin
            bcnt_n    = '0;
            ccnt_n    = ccnt + 1'b1;
            col_acc_n = col_next;
          end
          if (col_done) begin
            ccnt_n  = '0;
            wen_n   = 1'b1;
            wdata_n = col_next;
            wrow_n  = row;
            wcol_n  = col;
            if (col == CW'(COLUMNS - 1)) begin
              col_n = '0;
              if (row == last) state_n = DONE;
              else             row_n   = row + 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
        BRIGHT: begin
          bright_n = in_data;
          state_n  = DONE;
        end
        default: ;
      endcase
    end

    // EOT acts on the state reached after this cycle's byte.
    if (in_eot) begin
      unique case (state_n)
        ARGS, DATA, BRIGHT: begin
          error_n = 1'b1;
          state_n = IDLE;
        end
        DONE: begin
          loaded_n = 1'b1;
          state_n  = IDLE;
        end
        DROP:    state_n = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      last       <= '0;
      col        <= '0;
      bcnt       <= '0;
      ccnt       <= '0;
      ch_acc     <= '0;
      col_acc    <= '0;
      start      <= '0;
      argc       <= 1'b0;
      wdata      <= '0;
      wrow       <= '0;
      wcol       <= '0;
      wen        <= 1'b0;
      loaded     <= 1'b0;
      error      <= 1'b0;
      brightness <= BRIGHT_RESET;
    end else begin
      state      <= state_n;
      row        <= row_n;
      last       <= last_n;
      col        <= col_n;
      bcnt       <= bcnt_n;
      ccnt       <= ccnt_n;
      ch_acc     <= ch_acc_n;
      col_acc    <= col_acc_n;
      start      <= start_n;
      argc       <= argc_n;
      wdata      <= wdata_n;
      wrow       <= wrow_n;
      wcol       <= wcol_n;
      wen        <= wen_n;
      loaded     <= loaded_n;
      error      <= error_n;
      brightness <= bright_n;
    end
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboard bench for spi_frame_loader: 8-bit RGB instance (A)
// and a 12-bit single-channel instance (B).
module tb_spi_frame_loader;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [23:0] data;
  } ev_t;

  localparam logic [1:0] K_WEN = 2'd0;
  localparam logic [1:0] K_LD  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  din_a = '0, din_b = '0;
  logic        vld_a = 0, sot_a = 0, eot_a = 0, rdy_a = 1;
  logic        vld_b = 0, sot_b = 0, eot_b = 0, rdy_b = 1;
  logic [23:0] wdata_a;
  logic [11:0] wdata_b;
  logic [1:0]  wrow_a;
  logic [0:0]  wrow_b, wcol_a, wcol_b;
  logic        wen_a, wen_b, loaded_a, loaded_b;
  logic        error_a, error_b, busy_a, busy_b;
  logic [7:0]  bright_a, bright_b;

  spi_frame_loader #(
    .SEGMENTS(1), .ROWS(4), .COLUMNS(2),
    .CHANNELS(3), .BITWIDTH(8)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_data(din_a), .in_valid(vld_a),
    .in_sot(sot_a), .in_eot(eot_a),
    .ready(rdy_a),
    .wdata(wdata_a), .wen(wen_a),
    .wrow(wrow_a), .wcol(wcol_a),
    .loaded(loaded_a), .error(error_a),
    .brightness(bright_a), .busy(busy_a)
  );

  spi_frame_loader #(
    .SEGMENTS(1), .ROWS(2), .COLUMNS(2),
    .CHANNELS(1), .BITWIDTH(12)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_data(din_b), .in_valid(vld_b),
    .in_sot(sot_b), .in_eot(eot_b),
    .ready(rdy_b),
    .wdata(wdata_b), .wen(wen_b),
    .wrow(wrow_b), .wcol(wcol_b),
    .loaded(loaded_b), .error(error_b),
    .brightness(bright_b), .busy(busy_b)
  );

  ev_t qa[$];
  ev_t qb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk_val(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_ev(input string nm, input ev_t g,
                        input bit have, input ev_t e);
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL %s: unexpected kind=%0d r=%0d c=%0d d=%h, want none",
               nm, g.kind, g.row, g.col, g.data);
    end else if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got kind=%0d r=%0d c=%0d d=%h, want kind=%0d r=%0d c=%0d d=%h",
               nm, g.kind, g.row, g.col, g.data,
               e.kind, e.row, e.col, e.data);
    end
  endtask

  task automatic take_a(input ev_t g);
    ev_t e;
    bit  h;
    h = qa.size() != 0;
    if (h) e = qa.pop_front();
    else   e = '0;
    chk_ev("evA", g, h, e);
  endtask

  task automatic take_b(input ev_t g);
    ev_t e;
    bit  h;
    h = qb.size() != 0;
    if (h) e = qb.pop_front();
    else   e = '0;
    chk_ev("evB", g, h, e);
  endtask

  // Monitors: wen first, then loaded, then error within a cycle.
  always @(negedge clk) begin
    if (wen_a) take_a({K_WEN, 4'(wrow_a), 4'(wcol_a), wdata_a});
    if (loaded_a) take_a({K_LD, 4'd0, 4'd0, 24'd0});
    if (error_a) take_a({K_ERR, 4'd0, 4'd0, 24'd0});
    if (wen_b) take_b({K_WEN, 4'(wrow_b), 4'(wcol_b), 24'(wdata_b)});
    if (loaded_b) take_b({K_LD, 4'd0, 4'd0, 24'd0});
    if (error_b) take_b({K_ERR, 4'd0, 4'd0, 24'd0});
  end

  task automatic push(input bit b, input logic [1:0] k,
                      input int r, input int c,
                      input logic [23:0] d);
    ev_t e;
    e = {k, 4'(r), 4'(c), d};
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic idle_in();
    vld_a = 0; sot_a = 0; eot_a = 0;
    vld_b = 0; sot_b = 0; eot_b = 0;
  endtask

  task automatic send(input bit b, input logic [7:0] d,
                      input bit sot, input bit eot);
    if (b) begin
      din_b = d; vld_b = 1; sot_b = sot; eot_b = eot;
    end else begin
      din_a = d; vld_a = 1; sot_a = sot; eot_a = eot;
    end
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic eot(input bit b);
    if (b) eot_b = 1;
    else   eot_a = 1;
    @(posedge clk); #1;
    idle_in();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_wen_a", 32'(wen_a), 0);
    chk_val("rst_pulses_a", 32'({loaded_a, error_a}), 0);
    chk_val("rst_busy_a", 32'(busy_a), 0);
    chk_val("rst_bright_a", 32'(bright_a), 32'hFF);
    chk_val("rst_wdata_a", 32'(wdata_a), 0);
    chk_val("rst_wdata_b", 32'(wdata_b), 0);
    chk_val("rst_bright_b", 32'(bright_b), 32'hFF);
    chk_val("rst_busy_b", 32'(busy_b), 0);
    rst = 0;
    @(posedge clk); #1;

    // Full frame on A: 8 columns of bytes 01..18.
    for (int k = 0; k < 8; k++)
      push(0, K_WEN, k / 2, k % 2,
           {8'(3*k+1), 8'(3*k+2), 8'(3*k+3)});
    push(0, K_LD, 0, 0, 0);
    send(0, 8'hF0, 1, 0);
    chk_val("busy_data", 32'(busy_a), 1);
    for (int i = 1; i <= 24; i++) send(0, 8'(i), 0, 0);
    eot(0);
    chk_val("busy_after_ld", 32'(busy_a), 0);

    // Window row 2, last byte carries EOT.
    push(0, K_WEN, 2, 0, 24'h212223);
    push(0, K_WEN, 2, 1, 24'h242526);
    push(0, K_LD, 0, 0, 0);
    send(0, 8'hF1, 1, 0);
    send(0, 8'h02, 0, 0);
    send(0, 8'h01, 0, 0);
    for (int i = 8'h21; i <= 8'h25; i++) send(0, 8'(i), 0, 0);
    send(0, 8'h26, 0, 1);

    // Window overruns the rows, then a zero-count window.
    push(0, K_ERR, 0, 0, 0);
    send(0, 8'hF1, 1, 0);
    send(0, 8'h03, 0, 0);
    send(0, 8'h02, 0, 0);
    for (int i = 0; i < 6; i++) send(0, 8'h77, 0, 0);
    eot(0);
    push(0, K_ERR, 0, 0, 0);
    send(0, 8'hF1, 1, 0);
    send(0, 8'h00, 0, 0);
    send(0, 8'h00, 0, 0);
    eot(0);

    // Short frame aborted by EOT.
    push(0, K_WEN, 0, 0, 24'h313233);
    push(0, K_ERR, 0, 0, 0);
    send(0, 8'hF0, 1, 0);
    for (int i = 8'h31; i <= 8'h35; i++) send(0, 8'(i), 0, 0);
    eot(0);

    // New frame, then missing EOT: start byte F2 aborts and is decoded.
    push(0, K_WEN, 0, 0, 24'h414243);
    push(0, K_ERR, 0, 0, 0);
    push(0, K_LD, 0, 0, 0);
    send(0, 8'hF0, 1, 0);
    send(0, 8'h41, 0, 0);
    send(0, 8'h42, 0, 0);
    send(0, 8'h43, 0, 0);
    send(0, 8'hF2, 1, 0);
    send(0, 8'h55, 0, 0);
    eot(0);
    chk_val("bright_55", 32'(bright_a), 32'h55);

    // Rejects: unknown command, and F0 without ready.
    push(0, K_ERR, 0, 0, 0);
    send(0, 8'hA5, 1, 0);
    send(0, 8'h01, 0, 0);
    send(0, 8'h02, 0, 0);
    eot(0);
    chk_val("busy_after_drop", 32'(busy_a), 0);
    rdy_a = 0;
    push(0, K_ERR, 0, 0, 0);
    send(0, 8'hF0, 1, 0);
    for (int i = 0; i < 3; i++) send(0, 8'h99, 0, 0);
    eot(0);

    // Brightness ignores ready.
    push(0, K_LD, 0, 0, 0);
    send(0, 8'hF2, 1, 0);
    send(0, 8'h40, 0, 0);
    eot(0);
    chk_val("bright_40", 32'(bright_a), 32'h40);
    rdy_a = 1;
    push(0, K_ERR, 0, 0, 0);
    send(0, 8'hF2, 1, 0);
    eot(0);
    chk_val("bright_keep", 32'(bright_a), 32'h40);

    // Reset mid-DATA: no pulses, brightness restored.
    push(0, K_WEN, 0, 0, 24'h010203);
    send(0, 8'hF0, 1, 0);
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk_val("rst_mid_bright", 32'(bright_a), 32'hFF);
    chk_val("rst_mid_busy", 32'(busy_a), 0);

    // Instance B: 12-bit single channel, two bytes per channel.
    push(1, K_WEN, 0, 0, 24'hABC);
    push(1, K_WEN, 0, 1, 24'hFFF);
    push(1, K_WEN, 1, 0, 24'h234);
    push(1, K_WEN, 1, 1, 24'h567);
    push(1, K_LD, 0, 0, 0);
    send(1, 8'hF0, 1, 0);
    send(1, 8'h0A, 0, 0);
    send(1, 8'hBC, 0, 0);
    send(1, 8'h0F, 0, 0);
    send(1, 8'hFF, 0, 0);
    send(1, 8'h12, 0, 0);
    send(1, 8'h34, 0, 0);
    send(1, 8'hF5, 0, 0);
    send(1, 8'h67, 0, 1);

    repeat (5) @(posedge clk);
    #1;
    chk_val("drain_a", 32'(qa.size()), 0);
    chk_val("drain_b", 32'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_loader.md
# spi_frame_loader

Parametrised successor to the display SPI load path. Consumes the byte stream from `spi_slave`, decodes a one-byte command, and writes column words (SEGMENTS × CHANNELS × BITWIDTH bits) into the display framebuffer. It supports full-frame and row-window loads, multi-byte channel values, a brightness register, and explicit error reporting. It sits between `spi_slave` and the framebuffer write port.

## Interface
- SEGMENTS, 1, segments per column word
- ROWS, 8, addressable rows (≥2)
- COLUMNS, 32, columns per row (≥2)
- CHANNELS, 3, colour channels per segment (1–4)
- BITWIDTH, 8, bits per channel (1–16); BPC = ceil(BITWIDTH/8) bytes per channel
- BRIGHT_RESET, 8'hFF, reset value of `brightness`
- W = SEGMENTS*CHANNELS*BITWIDTH
- Reset: `rst`, synchronous, active-high. Clock: `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  byte from `spi_slave`
- in_valid  in  1  byte strobe
- in_sot  in  1  first byte of transaction (coincides with in_valid)
- in_eot  in  1  end-of-transaction pulse
- ready  in  1  framebuffer may accept a new load
- wdata  out  W  column word
- wen  out  1  one-cycle write strobe
- wrow  out  clog2(ROWS)  write row
- wcol  out  clog2(COLUMNS)  write column
- loaded  out  1  one-cycle pulse: load completed and EOT seen
- error  out  1  one-cycle pulse: rejected/aborted transaction
- brightness  out  8  global brightness register
- busy  out  1  high in any state other than IDLE

## Operation
- Reset values: all outputs 0 except `brightness`=BRIGHT_RESET. State returns to IDLE.
- States: IDLE, ARGS, DATA, DONE, BRIGHT, DROP.
- IDLE: a byte with in_sot selects the command.
  - 0xF0 with ready=1: enter DATA with row range 0..ROWS-1.
  - 0xF1 with ready=1: enter ARGS.
  - 0xF2: enter BRIGHT; ready is ignored.
  - Any other byte, or 0xF0/0xF1 with ready=0: pulse `error` and enter DROP.
- ARGS: byte 1 = start row S, byte 2 = count N.
  - S<ROWS, N≥1 and S+N≤ROWS: enter DATA with rows S..S+N-1.
  - Otherwise: pulse `error` on byte 2 and enter DROP.
- DATA: bytes arrive column-major within a row, then rows in ascending order. Within a column: segment 0 first; per segment, channel 0 first; per channel, BPC bytes MSB-first.
  - Each channel value takes the low BITWIDTH bits of its BPC-byte big-endian value.
  - Packing: the first-received channel occupies wdata[W-1 -: BITWIDTH].
  - When the last byte of a column is accepted, `wen` pulses with that column's wrow/wcol. Column then advances; after COLUMNS-1 it wraps to 0 and row advances.
  - After the last column of the last row in range: enter DONE.
- DONE: further bytes are ignored. in_eot pulses `loaded` and returns to IDLE.
- BRIGHT: the first data byte loads `brightness`; then enter DONE, so EOT also pulses `loaded`. EOT with no data byte pulses `error` and leaves `brightness` unchanged.
- DROP: ignore bytes until in_eot, then return to IDLE with no further pulses.
- EOT in ARGS or DATA before completion: pulse `error`, return to IDLE. Writes already issued stand.
- in_sot outside IDLE (missing EOT): pulse `error`, abort the current transaction, and decode this byte as a new command in the same cycle.
- in_valid and in_eot in the same cycle: consume the byte first, then apply EOT. A byte that completes the load therefore yields `wen` and `loaded` on the same edge.
- rst mid-transaction: abort immediately. No `wen`, `loaded`, or `error` pulse.

## Timing
- `wen`, `wrow`, `wcol`, `wdata`: registered, valid on the cycle after the completing byte's in_valid cycle. `wdata` holds until the next column completes.
- `loaded` and `error`: registered, one cycle after in_eot or the offending byte.
- `busy`: rises one cycle after the command byte; falls the cycle `loaded`/`error` is asserted on EOT.
- Throughput: one byte per clk; back-to-back in_valid is supported.

## Test plan
- Full frame (ROWS=2, COLUMNS=2, CHANNELS=3, BITWIDTH=8): F0 followed by bytes 01..0C, then EOT -> four `wen` pulses at (r,c) (0,0)=010203, (0,1)=040506, (1,0)=0708 09, (1,1)=0A0B0C; `loaded` pulse; `error` stays 0.
- Window (ROWS=4): F1,02,01 + 6 bytes -> `wen` at (2,0) and (2,1) only; `loaded` pulse. F1,03,02 -> `error` pulse, no `wen`.
- Short frame: F0 + 5 bytes, then EOT -> one `wen` at (0,0); `error` pulse; no `loaded`; next F0 is accepted.
- Rejects: 0xA5 command, or F0 with ready=0 -> `error` pulse; data ignored; IDLE after EOT; no `wen`.
- BITWIDTH=12, CHANNELS=1, COLUMNS=2, ROWS=2: F0,0A,BC,0F,FF,… -> (0,0)=ABC, (0,1)=FFF.
- Brightness: F2,40,EOT -> `brightness`=40, `loaded` pulse. F2,EOT -> `error` pulse, `brightness` unchanged. rst mid-DATA -> `brightness`=FF and no pulses.
